// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell sequenced over WIDTH cycles, LSB first.
// Optional macro SERIAL_ADD_OVF_EN adds the signed-overflow output Ovf.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_r;
  logic             carry;
  logic             cout_r;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_c;
  logic             accept;
  logic             last;

  // The single shared full-adder cell.
  assign fa_s   = a_sh[0] ^ b_sh[0] ^ carry;
  assign fa_c   = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
  assign accept = Start && (state != RUN);
  assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      IDLE: begin
        if (Start) state_nxt = RUN;
      end
      RUN: begin
        Busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        Done      = 1'b1;
        state_nxt = Start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sh  <= A;
      b_sh  <= B;
      carry <= Cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      // Result bits enter at the MSB so bit 0 lands at position 0 after WIDTH shifts.
      sum_r <= {fa_s, sum_r[WIDTH-1:1]};
      carry <= fa_c;
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      if (last) begin
        cout_r <= fa_c;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_r;

  // On the final bit, the carry register holds the carry into the MSB.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ovf_r <= 1'b0;
    end else if (accept) begin
      ovf_r <= 1'b0;
    end else if (last) begin
      ovf_r <= carry ^ fa_c;
    end
  end

  assign Ovf = ovf_r;
`endif

  assign Sum  = sum_r;
  assign Cout = cout_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed plus randomized bench for serial_add_ctrl, checked against an arithmetic reference.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         Clk;
  logic         Rst_n;
  logic         Start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Sum;
  logic         Cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         Ovf;
`endif

  int tests = 0;
  int fails = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Start (Start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .Busy  (Busy),
    .Done  (Done),
    .Sum   (Sum),
    .Cout  (Cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .Ovf   (Ovf)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_b(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_v(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer addition; overflow when the signed result leaves range.
  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    return (W+1)'(a) + (W+1)'(b) + (W+1)'(c);
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c);
    int s;
    s = int'($signed(a)) + int'($signed(b)) + int'(c);
    return (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
  endfunction

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    A     = a;
    B     = b;
    Cin   = c;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    A     = W'($urandom);
    B     = W'($urandom);
    Cin   = 1'($urandom);
  endtask

  // Checks WIDTH busy cycles, then the Done cycle. poke >= 0 raises Start mid-run.
  task automatic wait_result(input string tag, input logic [W:0] exp, input logic exp_ovf,
                             input int poke);
    for (int j = 0; j < W; j++) begin
      check_b({tag, " busy"}, Busy, 1'b1);
      check_b({tag, " done_early"}, Done, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
      if (j == 0) check_b({tag, " ovf_clr"}, Ovf, 1'b0);
`endif
      if (j == poke) begin
        Start = 1'b1;
        A     = 8'hAA;
        B     = 8'h55;
      end else if (j == poke + 1) begin
        Start = 1'b0;
      end
      @(negedge Clk);
    end
    check_b({tag, " done"}, Done, 1'b1);
    check_b({tag, " busy_in_done"}, Busy, 1'b0);
    check_v({tag, " sum"}, Sum, exp[W-1:0]);
    check_b({tag, " cout"}, Cout, exp[W]);
`ifdef SERIAL_ADD_OVF_EN
    check_b({tag, " ovf"}, Ovf, exp_ovf);
`else
    if (exp_ovf === 1'bx) $display("unreachable");
`endif
  endtask

  task automatic run_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input int poke);
    logic [W:0] exp;
    exp = ref_add(a, b, c);
    accept(a, b, c);
    wait_result(tag, exp, ref_ovf(a, b, c), poke);
    @(negedge Clk);
    check_b({tag, " done_pulse"}, Done, 1'b0);
    check_b({tag, " idle_busy"}, Busy, 1'b0);
    check_v({tag, " sum_held"}, Sum, exp[W-1:0]);
    check_b({tag, " cout_held"}, Cout, exp[W]);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;

    Rst_n = 1'b0;
    Start = 1'b0;
    A     = '0;
    B     = '0;
    Cin   = 1'b0;
    #3;
    check_b("rst busy", Busy, 1'b0);
    check_b("rst done", Done, 1'b0);
    check_v("rst sum", Sum, '0);
    check_b("rst cout", Cout, 1'b0);
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);

    run_one("basic", 8'h35, 8'h4A, 1'b0, -1);
    run_one("ff_ff_cin", 8'hFF, 8'hFF, 1'b1, -1);
    run_one("ff_01", 8'hFF, 8'h01, 1'b0, -1);
    run_one("start_busy", 8'h10, 8'h20, 1'b0, 3);
    run_one("ovf_pos", 8'h7F, 8'h01, 1'b0, -1);
    run_one("ovf_neg", 8'h80, 8'h80, 1'b0, -1);

    // Back-to-back: Start held through the Done cycle.
    accept(8'h10, 8'h20, 1'b0);
    wait_result("b2b_first", ref_add(8'h10, 8'h20, 1'b0), 1'b0, -1);
    A     = 8'h01;
    B     = 8'h01;
    Cin   = 1'b0;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    A     = 8'hC3;
    wait_result("b2b_second", ref_add(8'h01, 8'h01, 1'b0), 1'b0, -1);
    @(negedge Clk);
    check_b("b2b idle", Done, 1'b0);

    // Asynchronous reset in the middle of an add.
    accept(8'h6C, 8'h5D, 1'b1);
    repeat (3) @(negedge Clk);
    check_b("abort busy_before", Busy, 1'b1);
    #2 Rst_n = 1'b0;
    #1;
    check_b("abort busy", Busy, 1'b0);
    check_b("abort done", Done, 1'b0);
    check_v("abort sum", Sum, '0);
    check_b("abort cout", Cout, 1'b0);
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge Clk);
      check_b("abort no_done", Done, 1'b0);
      check_b("abort no_busy", Busy, 1'b0);
    end
    run_one("after_abort", 8'h35, 8'h4A, 1'b0, -1);

    for (int i = 0; i < 16; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      run_one($sformatf("rand%0d", i), ra, rb, rc, (i % 4 == 0) ? 2 : -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller. Sequences a single 1-bit full-adder datapath over WIDTH cycles to add two WIDTH-bit operands, LSB first.
- Holds a registered carry between bits.
- Sits between a requester (start/done handshake) and the FA cell, so multi-bit adds cost one FA instead of WIDTH.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- Clk  input  1  system clock, rising-edge.
- Rst_n  input  1  asynchronous active-low reset.
- Start  input  1  request; sampled on rising Clk edge.
- A  input  WIDTH  operand A; captured when Start is accepted.
- B  input  WIDTH  operand B; captured when Start is accepted.
- Cin  input  1  carry-in; captured when Start is accepted.
- Busy  output  1  high while an add is in progress (RUN state).
- Done  output  1  single-cycle pulse; result valid.
- Sum  output  WIDTH  result; held stable from Done until next accepted Start.
- Cout  output  1  carry-out of MSB; held with Sum.

Behaviour:
- Clock and reset: one clock domain (Clk); reset is asynchronous and active-low (Rst_n).
- Reset values: state=IDLE, Busy=0, Done=0, Sum=0, Cout=0, internal carry=0, bit counter=0, operand shift registers=0.
- States:
  - IDLE: Busy=0, Done=0.
  - RUN: Busy=1.
  - DONE: Done=1 for exactly one cycle, Busy=0.
- Accepting a request: Start=1 sampled in IDLE or DONE:
  - load A/B shift regs, load carry<=Cin, counter<=0, go to RUN.
  - Start is ignored in RUN; no queueing.
- RUN, each edge:
  - FA inputs are A_sh[0], B_sh[0] and the carry reg.
  - FA sum bit shifts into Sum from the MSB end (Sum <= {s, Sum[WIDTH-1:1]}).
  - carry <= FA carry; A_sh and B_sh shift right by 1; counter increments.
- Leaving RUN: on the edge where counter==WIDTH-1, the last bit is processed, Cout <= FA carry, and the state goes to DONE.
- Latency: Start sampled at edge k gives RUN for edges k+1..k+WIDTH. Done is high during the cycle after edge k+WIDTH.
- DONE: if Start=0, go to IDLE. If Start=1, restart immediately (back-to-back); Sum and Cout then begin updating from the next edge.
- Sum during RUN: partial/shifting, not valid. Consumers must sample only on Done or while idle.
- Counter width is clog2(WIDTH); it never wraps because the state leaves RUN at WIDTH-1.
- Reset mid-operation: immediate return to reset values. No Done is produced for the aborted add.
- Operands changing after acceptance have no effect on the in-flight add.
- X on Start in IDLE is a bench error; no defined behaviour is required.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- Defined: adds output port Ovf (1 bit), the signed-overflow flag.
  - Ovf = carry-into-MSB XOR Cout, captured at the final RUN edge.
  - Held with Sum; reset to 0; cleared at the next accepted Start.
- Undefined: no Ovf port and no related logic. Port list and timing are otherwise identical.

Test Plan (WIDTH=8):
- Basic add: A=8'h35, B=8'h4A, Cin=0, Start pulse → Done exactly 8 cycles after the start edge; Sum=8'h7F, Cout=0; Busy high for 8 cycles.
- Carry chain plus Cin: A=8'hFF, B=8'hFF, Cin=1 → Sum=8'hFF, Cout=1. Then A=8'hFF, B=8'h01, Cin=0 → Sum=8'h00, Cout=1.
- Start while busy: start A=8'h10, B=8'h20. At RUN cycle 3, assert Start with A=8'hAA, B=8'h55 → ignored; single Done; Sum=8'h30, Cout=0.
- Back-to-back: hold Start=1 through the Done cycle with new A=8'h01, B=8'h01 → the first Done shows the first result. A second Done follows 8 cycles later with Sum=8'h02; Busy low only during the Done cycle.
- Reset mid-op: assert Rst_n=0 asynchronously at RUN cycle 4 → Busy, Done, Sum and Cout go to 0 immediately, with no later Done. A new Start after release gives a correct result.
- With SERIAL_ADD_OVF_EN:
  - A=8'h7F, B=8'h01 → Sum=8'h80, Ovf=1, Cout=0.
  - A=8'h80, B=8'h80 → Sum=8'h00, Ovf=1, Cout=1.
  - A=8'h35, B=8'h4A → Ovf=0.
